// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Time-setting controller for the watch datapath. Debounces
//               the raw active-low mode/cancel keys, walks
//               RUN -> SET_H -> SET_M -> SET_S -> RUN, issues clamped
//               single-cycle load strobes, gates watch counting and blinks
//               the field being edited.
//               Optional build macro: TIME_SET_AUTO_EXIT_EN (idle auto-exit
//               from the SET states after TIMEOUT_S seconds).
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HZ        = 2,
    parameter int TIMEOUT_S       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn_n,
    input  logic       cancel_btn_n,
    input  logic [5:0] val,
    output logic       run_en,
    output logic       load_h,
    output logic       load_m,
    output logic       load_s,
    output logic [5:0] load_val,
    output logic [1:0] field,
    output logic       blink
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int c_HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_BLINK_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_BLINK_W-1:0] c_HALF_LAST = c_BLINK_W'(c_HALF - 1);

    localparam logic [5:0] c_MAX_HOUR = 6'd23;
    localparam logic [5:0] c_MAX_MIN  = 6'd59;

    // State encoding doubles as the field code driven on the field output.
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_SET_H = 2'd1;
    localparam logic [1:0] S_SET_M = 2'd2;
    localparam logic [1:0] S_SET_S = 2'd3;

    // ------------------------------------------------------------------------
    // Key conditioning: bit 0 = mode, bit 1 = cancel
    // ------------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] w_key_evt;

    assign w_key_raw = {cancel_btn_n, mode_btn_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic [1:0]        r_sync;
        logic              r_db;   // debounced level, 1 = released
        logic [c_DB_W-1:0] r_cnt;
        logic              r_evt;

        // Synchronise, debounce, and pulse once on the debounced press edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= 2'b11;
                r_db   <= 1'b1;
                r_cnt  <= '0;
                r_evt  <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_key_raw[gi]};
                r_evt  <= 1'b0;
                if (r_sync[1] != r_db) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_db  <= r_sync[1];
                        r_cnt <= '0;
                        // Only the released->pressed transition is an event.
                        r_evt <= ~r_sync[1];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_key_evt[gi] = r_evt;
    end

    logic w_mode_evt;
    logic w_cancel_evt;

    assign w_mode_evt   = w_key_evt[0];
    assign w_cancel_evt = w_key_evt[1];

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           r_field;
    logic                 r_run_en;
    logic                 r_load_h;
    logic                 r_load_m;
    logic                 r_load_s;
    logic [5:0]           r_load_val;
    logic                 r_blink;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 w_timeout;

    // ------------------------------------------------------------------------
    // Optional idle auto-exit
    // ------------------------------------------------------------------------
`ifdef TIME_SET_AUTO_EXIT_EN
    localparam int c_IDLE_LIMIT = TIMEOUT_S * CLK_HZ;
    localparam int c_IDLE_W     = (c_IDLE_LIMIT > 1) ? $clog2(c_IDLE_LIMIT) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(c_IDLE_LIMIT - 1);

    logic [c_IDLE_W-1:0] r_idle_cnt;

    // Count idle cycles while editing; any key press restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state == S_RUN) || w_mode_evt || w_cancel_evt || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != S_RUN) && (r_idle_cnt == c_IDLE_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Clamped switch values
    // ------------------------------------------------------------------------
    logic [5:0] w_hour_val;
    logic [5:0] w_min_val;

    assign w_hour_val = (val > c_MAX_HOUR) ? c_MAX_HOUR : val;
    assign w_min_val  = (val > c_MAX_MIN)  ? c_MAX_MIN  : val;

    // Setting FSM with registered strobes, field decode, run gate and blink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_field     <= S_RUN;
            r_run_en    <= 1'b1;
            r_load_h    <= 1'b0;
            r_load_m    <= 1'b0;
            r_load_s    <= 1'b0;
            r_load_val  <= '0;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            // Strobes and their value live for exactly one cycle.
            r_load_h   <= 1'b0;
            r_load_m   <= 1'b0;
            r_load_s   <= 1'b0;
            r_load_val <= '0;

            // Free-running blink while editing, steady on while running.
            if (r_state == S_RUN) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == c_HALF_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if ((w_cancel_evt || w_timeout) && (r_state != S_RUN)) begin
                // Abandon the edit; fields already loaded stay loaded.
                r_state     <= S_RUN;
                r_field     <= S_RUN;
                r_run_en    <= 1'b1;
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (w_mode_evt && !w_cancel_evt) begin
                // Every mode transition lands in a fresh blink phase.
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
                case (r_state)
                    S_RUN: begin
                        r_state  <= S_SET_H;
                        r_field  <= S_SET_H;
                        r_run_en <= 1'b0;
                    end
                    S_SET_H: begin
                        r_load_h   <= 1'b1;
                        r_load_val <= w_hour_val;
                        r_state    <= S_SET_M;
                        r_field    <= S_SET_M;
                    end
                    S_SET_M: begin
                        r_load_m   <= 1'b1;
                        r_load_val <= w_min_val;
                        r_state    <= S_SET_S;
                        r_field    <= S_SET_S;
                    end
                    default: begin
                        r_load_s   <= 1'b1;
                        r_load_val <= w_min_val;
                        r_state    <= S_RUN;
                        r_field    <= S_RUN;
                        r_run_en   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign run_en   = r_run_en;
    assign load_h   = r_load_h;
    assign load_m   = r_load_m;
    assign load_s   = r_load_s;
    assign load_val = r_load_val;
    assign field    = r_field;
    assign blink    = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed self-checking bench for time_set_ctrl with
//               DEBOUNCE_CYCLES=4, CLK_HZ=40, BLINK_HZ=2 (HALF=10),
//               TIMEOUT_S=1. Auto-exit steps follow TIME_SET_AUTO_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_btn_n;
    logic       cancel_btn_n;
    logic [5:0] val;
    logic       run_en;
    logic       load_h;
    logic       load_m;
    logic       load_s;
    logic [5:0] load_val;
    logic [1:0] field;
    logic       blink;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .CLK_HZ          (40),
        .DEBOUNCE_CYCLES (4),
        .BLINK_HZ        (2),
        .TIMEOUT_S       (1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_btn_n   (mode_btn_n),
        .cancel_btn_n (cancel_btn_n),
        .val          (val),
        .run_en       (run_en),
        .load_h       (load_h),
        .load_m       (load_m),
        .load_s       (load_s),
        .load_val     (load_val),
        .field        (field),
        .blink        (blink)
    );

    int total = 0;
    int bad   = 0;

    // Strobe bookkeeping sampled on the falling edge.
    int         n_h = 0;
    int         n_m = 0;
    int         n_s = 0;
    int         viol = 0;
    logic [5:0] last_h = '0;
    logic [5:0] last_m = '0;
    logic [5:0] last_s = '0;
    logic       prev_any = 1'b0;

    always @(negedge clk) begin
        if (load_h === 1'b1) begin n_h++; last_h = load_val; end
        if (load_m === 1'b1) begin n_m++; last_m = load_val; end
        if (load_s === 1'b1) begin n_s++; last_s = load_val; end
        if ((int'(load_h) + int'(load_m) + int'(load_s)) > 1) viol++;
        if (prev_any && (load_h | load_m | load_s)) viol++;
        if (!(load_h | load_m | load_s) && (load_val !== 6'd0)) viol++;
        prev_any = load_h | load_m | load_s;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_field(input logic [1:0] tgt, input int bound, output int n);
        n = 0;
        while ((field !== tgt) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic press(input bit m, input bit c, input int hold);
        if (m) mode_btn_n = 1'b0;
        if (c) cancel_btn_n = 1'b0;
        step(hold);
        mode_btn_n   = 1'b1;
        cancel_btn_n = 1'b1;
        step(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;

        rst_n        = 1'b0;
        mode_btn_n   = 1'b1;
        cancel_btn_n = 1'b1;
        val          = 6'd0;
        step(3);
        chk("rst_run_en", run_en, 1);
        chk("rst_field", field, 0);
        chk("rst_blink", blink, 1);
        chk("rst_strobes", {load_h, load_m, load_s}, 0);
        chk("rst_load_val", load_val, 0);

        // Idle in RUN for 100 cycles.
        rst_n = 1'b1;
        errs  = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (field !== 2'd0 || run_en !== 1'b1 || blink !== 1'b1) errs++;
        end
        chk("idle_run_errs", errs, 0);
        chk("idle_no_strobe", n_h + n_m + n_s, 0);

        // Long mode hold: one transition, latency window, blink pattern.
        mode_btn_n = 1'b0;
        wait_field(2'd1, 20, n);
        chk("enter_seth", field, 1);
        chk("enter_latency_ok", (n >= 6 && n <= 8), 1);
        chk("seth_run_en", run_en, 0);
        chk("blink_k0", blink, 1);
        step(9);
        chk("blink_k9", blink, 1);
        step(1);
        chk("blink_k10", blink, 0);
        step(9);
        chk("blink_k19", blink, 0);
        step(1);
        chk("blink_k20", blink, 1);
        step(50 - n - 20);
        mode_btn_n = 1'b1;
        step(20);
        chk("hold_single_trans", field, 1);
        chk("hold_no_strobe", n_h + n_m + n_s, 0);

        // Full set sequence with clamping.
        val = 6'd30;
        press(1, 0, 8);
        chk("load_h_cnt", n_h, 1);
        chk("load_h_val", last_h, 23);
        chk("field_setm", field, 2);
        val = 6'd45;
        press(1, 0, 8);
        chk("load_m_cnt", n_m, 1);
        chk("load_m_val", last_m, 45);
        chk("field_sets", field, 3);
        val = 6'd59;
        press(1, 0, 8);
        chk("load_s_cnt", n_s, 1);
        chk("load_s_val", last_s, 59);
        chk("back_run_field", field, 0);
        chk("back_run_en", run_en, 1);
        chk("back_run_blink", blink, 1);

        // Cancel out of SET_M after one hour load.
        press(1, 0, 8);
        val = 6'd10;
        press(1, 0, 8);
        chk("cancel_pre_field", field, 2);
        chk("cancel_pre_h_cnt", n_h, 2);
        chk("cancel_pre_h_val", last_h, 10);
        val = 6'd50;
        press(0, 1, 8);
        chk("cancel_field", field, 0);
        chk("cancel_run_en", run_en, 1);
        chk("cancel_h_cnt", n_h, 2);
        chk("cancel_m_cnt", n_m, 1);
        chk("cancel_s_cnt", n_s, 1);

        // Short glitch is ignored.
        mode_btn_n = 1'b0;
        step(3);
        mode_btn_n = 1'b1;
        step(15);
        chk("glitch_field", field, 0);

        // Cancel in RUN does nothing.
        press(0, 1, 8);
        chk("run_cancel_field", field, 0);
        chk("run_cancel_en", run_en, 1);

        // Simultaneous mode+cancel in SET_H: cancel wins.
        press(1, 0, 8);
        chk("simul_pre_field", field, 1);
        press(1, 1, 8);
        chk("simul_field", field, 0);
        chk("simul_h_cnt", n_h, 2);

        // Reset in the middle of SET_S.
        val = 6'd5;
        press(1, 0, 8);
        press(1, 0, 8);
        press(1, 0, 8);
        chk("rst_mid_pre_field", field, 3);
        chk("rst_mid_pre_h", n_h, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_field", field, 0);
        chk("rst_mid_run_en", run_en, 1);
        chk("rst_mid_blink", blink, 1);
        chk("rst_mid_strobes", {load_h, load_m, load_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(20);
        chk("rst_mid_s_cnt", n_s, 1);
        chk("rst_mid_after_field", field, 0);

        // Idle behaviour in SET_H.
        mode_btn_n = 1'b0;
        wait_field(2'd1, 20, n);
        chk("idle_enter_seth", field, 1);
        mode_btn_n = 1'b1;
`ifdef TIME_SET_AUTO_EXIT_EN
        wait_field(2'd0, 80, n);
        chk("auto_exit_field", field, 0);
        chk("auto_exit_time_ok", (n >= 38 && n <= 42), 1);
        chk("auto_exit_run_en", run_en, 1);
        chk("auto_exit_h_cnt", n_h, 3);
`else
        step(80);
        chk("no_auto_exit_field", field, 1);
        press(0, 1, 8);
        chk("no_auto_exit_cancel", field, 0);
        chk("no_auto_exit_h_cnt", n_h, 3);
`endif

        chk("strobe_rule_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
